// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial line, word buffer handshake and status signals of serial_frame_rx.
// The receiver uses the slave modport. The bit source and the word consumer use the master modport.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             serial_en;
    logic             data_ready;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        output serial_in, serial_en, data_ready, err_clr,
        input  data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  serial_in, serial_en, data_ready, err_clr,
        output data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver. It takes the bit stream coming from universal_shift_reg and rebuilds WIDTH-bit words.
// A frame is a start bit (0), the data bits, an optional even-parity bit and a stop bit (1).
// Each word is presented on a one-entry valid/ready buffer. frame_err and overrun are sticky error flags.
//
// state  | meaning
// IDLE   | waiting for a start bit (sample of 0)
// DATA   | shifting in WIDTH data bits
// PARITY | capturing the parity bit (only when PARITY_EN)
// STOP   | checking the stop bit and delivering or dropping the word
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_frame_rx_if.slave  rx_if
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             rx_par_q, rx_par_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             busy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. The FSM only moves on strobed samples.
    always_comb begin
        state_d = state_q;
        if (rx_if.serial_en) begin
            case (state_q)
                IDLE:    if (!rx_if.serial_in) state_d = DATA;
                DATA:    if (cnt_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath: shift register, parity capture, output buffer and sticky flags
    always_comb begin
        logic good_stop;
        logic bad_stop;
        logic drain;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        rx_par_d  = rx_par_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        drain     = valid_q && rx_if.data_ready;

        if (rx_if.serial_en) begin
            case (state_q)
                IDLE:   if (!rx_if.serial_in) cnt_d = '0;
                DATA: begin
                    if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], rx_if.serial_in};
                    else           sr_d = {rx_if.serial_in, sr_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                end
                PARITY: rx_par_d = rx_if.serial_in;
                STOP: begin
                    good_stop = rx_if.serial_in;
                    bad_stop  = !rx_if.serial_in;
                end
                default: ;
            endcase
        end

        if (drain) valid_d = 1'b0;

        if (rx_if.err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        // A slot freed by a drain in the same cycle can take the new word.
        if (good_stop) begin
            if (!valid_q || drain) begin
                data_d  = sr_q;
                perr_d  = PARITY_EN ? ((^sr_q) ^ rx_par_q) : 1'b0;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (bad_stop) ferr_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            rx_par_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            rx_par_q <= rx_par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
    assign rx_if.busy       = busy;
endmodule
